// File: rtl/booth_mult_if.sv
// Operand/result bundle for booth_mult: start strobe with operands in, pulsed product out.
interface booth_mult_if #(
    parameter int unsigned WIDTH_INPUT  = 16,
    parameter int unsigned WIDTH_OUTPUT = 32
) ();
    logic [WIDTH_INPUT-1:0]  in_a;
    logic [WIDTH_INPUT-1:0]  in_b;
    logic                    valid_in;
    logic                    valid_out;
    logic [WIDTH_OUTPUT-1:0] product;

    modport master (
        output in_a,
        output in_b,
        output valid_in,
        input  valid_out,
        input  product
    );

    modport slave (
        input  in_a,
        input  in_b,
        input  valid_in,
        output valid_out,
        output product
    );
endinterface

// File: rtl/booth_mult.sv
// Sequential signed Booth multiplier, radix-2 by default.
// Define BOOTH_RADIX4_EN for modified-Booth radix-4 recoding (half the iterations).
module booth_mult #(
    parameter int unsigned WIDTH_INPUT  = 16,
    parameter int unsigned WIDTH_OUTPUT = 32
) (
    input  logic         clk,
    input  logic         reset,
    booth_mult_if.slave  bus
);

`ifdef BOOTH_RADIX4_EN
    localparam int unsigned AW    = WIDTH_INPUT + 2;
    localparam int unsigned ITERS = WIDTH_INPUT / 2;
`else
    localparam int unsigned AW    = WIDTH_INPUT + 1;
    localparam int unsigned ITERS = WIDTH_INPUT;
`endif
    localparam int unsigned CNT_W = $clog2(ITERS + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e                  state_q, state_d;
    logic [WIDTH_INPUT-1:0]  m_q, m_d;
    logic [AW-1:0]           a_q, a_d;
    logic [WIDTH_INPUT-1:0]  q_q, q_d;
    logic                    qm1_q, qm1_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WIDTH_OUTPUT-1:0] product_q, product_d;
    logic                    valid_out_q, valid_out_d;

    logic [AW-1:0]           m_ext;
    logic [AW-1:0]           a_sum;
    logic [AW-1:0]           a_next;
    logic [WIDTH_INPUT-1:0]  q_next;
    logic                    qm1_next;

    assign m_ext = {{(AW-WIDTH_INPUT){m_q[WIDTH_INPUT-1]}}, m_q};

    // One Booth step: recode, add/subtract into A, then arithmetic shift of {A, Q, Q-1}.
    always_comb begin
        a_sum = a_q;
`ifdef BOOTH_RADIX4_EN
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: a_sum = a_q + m_ext;
            3'b011:         a_sum = a_q + {m_ext[AW-2:0], 1'b0};
            3'b100:         a_sum = a_q - {m_ext[AW-2:0], 1'b0};
            3'b101, 3'b110: a_sum = a_q - m_ext;
            default:        a_sum = a_q;
        endcase
        a_next   = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
        q_next   = {a_sum[1:0], q_q[WIDTH_INPUT-1:2]};
        qm1_next = q_q[1];
`else
        case ({q_q[0], qm1_q})
            2'b01:   a_sum = a_q + m_ext;
            2'b10:   a_sum = a_q - m_ext;
            default: a_sum = a_q;
        endcase
        a_next   = {a_sum[AW-1], a_sum[AW-1:1]};
        q_next   = {a_sum[0], q_q[WIDTH_INPUT-1:1]};
        qm1_next = q_q[0];
`endif
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        a_d         = a_q;
        q_d         = q_q;
        qm1_d       = qm1_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        valid_out_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    state_d = CALC;
                    m_d     = bus.in_a;
                    q_d     = bus.in_b;
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = CNT_W'(ITERS);
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    a_d   = a_next;
                    q_d   = q_next;
                    qm1_d = qm1_next;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d     = DONE;
                    product_d   = WIDTH_OUTPUT'({a_q, q_q});
                    valid_out_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            m_q         <= '0;
            a_q         <= '0;
            q_q         <= '0;
            qm1_q       <= 1'b0;
            cnt_q       <= '0;
            product_q   <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            a_q         <= a_d;
            q_q         <= q_d;
            qm1_q       <= qm1_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign bus.valid_out = valid_out_q;
    assign bus.product   = product_q;

endmodule

// File: tb/tb_booth_mult.sv
// Randomized self-checking bench for booth_mult against a plain signed-multiply model.
module tb_booth_mult;

    localparam int W  = 16;
    localparam int WO = 32;
`ifdef BOOTH_RADIX4_EN
    localparam int LAT = W / 2 + 1;
`else
    localparam int LAT = W + 1;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   pulses;

    booth_mult_if #(.WIDTH_INPUT(W), .WIDTH_OUTPUT(WO)) bus ();

    booth_mult #(.WIDTH_INPUT(W), .WIDTH_OUTPUT(WO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.valid_out === 1'b1) pulses++;
    end

    function automatic logic [WO-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return WO'(pa * pb);
    endfunction

    task automatic check(input string tag, input logic [WO-1:0] got, input logic [WO-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Start one operation, optionally inject a second strobe at cycle inj_k, and check the result.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [WO-1:0] exp, input int inj_k,
                          input logic [W-1:0] ia, input logic [W-1:0] ib);
        int seen;
        int p0;
        p0 = pulses;
        @(negedge clk);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.valid_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.in_a     = W'($urandom());
        bus.in_b     = W'($urandom());
        seen = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.valid_in = (k == inj_k);
            if (k == inj_k) begin
                bus.in_a = ia;
                bus.in_b = ib;
            end
            if (bus.valid_out === 1'b1) begin
                seen = k;
                break;
            end
        end
        check({tag, "_latency"}, WO'(seen), WO'(LAT));
        check({tag, "_product"}, bus.product, exp);
        @(negedge clk);
        bus.valid_in = 1'b0;
        check({tag, "_pulse_end"}, WO'(bus.valid_out), '0);
        repeat (4) @(negedge clk);
        check({tag, "_hold"}, bus.product, exp);
        repeat (LAT + 4) @(negedge clk);
        check({tag, "_one_pulse"}, WO'(pulses - p0), WO'(1));
        check({tag, "_still_held"}, bus.product, exp);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           p0;
        clk          = 1'b0;
        reset        = 1'b0;
        checks       = 0;
        failures     = 0;
        pulses       = 0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.valid_in = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_valid_out", WO'(bus.valid_out), '0);
        check("rst_product", bus.product, '0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_valid_out", WO'(bus.valid_out), '0);
        check("post_rst_product", bus.product, '0);

        run_op("mul_3_m7", W'(3), W'(-7), 32'hFFFF_FFEB, -1, '0, '0);
        run_op("min_min", 16'h8000, 16'h8000, 32'h4000_0000, -1, '0, '0);
        run_op("min_max", 16'h8000, 16'h7FFF, 32'hC000_8000, -1, '0, '0);
        run_op("zero_a", 16'h0000, 16'h1234, 32'h0000_0000, -1, '0, '0);

        for (int i = 0; i < 5; i++) begin
            ra = W'($urandom());
            rb = W'($urandom());
            run_op($sformatf("rand%0d", i), ra, rb, ref_mul(ra, rb), -1, '0, '0);
        end

        // Second strobe mid-calculation and another during DONE must both be dropped.
        run_op("drop_calc", W'(5), W'(5), 32'h0000_0019, 5, W'(9), W'(9));
        run_op("drop_done", W'(-2), W'(4), ref_mul(W'(-2), W'(4)), LAT, W'(9), W'(9));

        // Reset during CALC aborts the operation with no pulse and clears product.
        p0 = pulses;
        @(negedge clk);
        bus.in_a     = W'(100);
        bus.in_b     = W'(-100);
        bus.valid_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_valid_out", WO'(bus.valid_out), '0);
        check("abort_product", bus.product, '0);
        reset = 1'b1;
        repeat (LAT + 5) @(negedge clk);
        check("abort_no_pulse", WO'(pulses - p0), '0);
        check("abort_product_idle", bus.product, '0);
        run_op("after_abort", W'(2), W'(3), 32'h0000_0006, -1, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
